lcd_read_nibbles: RTL and testbench
===================================

// Module: lcd_read_nibbles
// PURPOSE
// - Read-direction engine for the Spartan-3E character LCD 4-bit bus (HD44780-compatible).
// - Performs one two-nibble read cycle with lcd_rw=1:
//   - rs_sel=0: busy flag + address counter.
//   - rs_sel=1: data RAM byte.
// - Sits beside the power-up/command write path. The top level muxes lcd_rs/lcd_rw/lcd_e
//   and tristates sf_d while bus_release=1.
// PARAMETERS
// T_SETUP   2   cycles RS/RW stable before E rises (40 ns at 50 MHz)
// T_EHIGH   12  cycles E high per nibble (230 ns min)
// T_NIBGAP  50  cycles E low between nibbles / between polls (1 us)
// T_HOLD    1   cycles RW held high after final E fall
// POLL_MAX  1000 max status reads before timeout (LCD_BUSY_POLL_EN only)
// PORTS
// clk          in   1  system clock, 50 MHz
// rst          in   1  asynchronous, active-high reset
// start        in   1  request a read; accepted only when ready=1
// rs_sel       in   1  RS for the read; captured on accept
// sf_d_in      in   4  LCD data pins SF_D[11:8] as seen from the pad
// lcd_rs       out  1  LCD register select
// lcd_rw       out  1  LCD read/write (1 = read)
// lcd_e        out  1  LCD enable strobe
// bus_release  out  1  1 = top level must tristate sf_d
// data         out  8  assembled byte {high nibble, low nibble}
// busy_flag    out  1  data[7] when the read was a status read (rs_sel=0), else 0
// addr         out  7  data[6:0]
// valid        out  1  one-cycle pulse: data/busy_flag/addr updated
// ready        out  1  idle; start is accepted
// timeout      out  1  pulses with valid on poll timeout (0 when feature absent)
// BEHAVIOUR
// - Reset values (async, immediate, including mid-read):
//   - lcd_e=0, lcd_rw=0, lcd_rs=0, bus_release=0.
//   - data=0, busy_flag=0, valid=0, timeout=0, ready=1.
// - Reset mid-read drops E at once. The FSM returns to IDLE; no valid is produced.
// - States and timeline (cycle 0 = start && ready, ready drops in cycle 1):
//   - IDLE: waits for start && ready.
//   - RELEASE: 1 cycle (cycle 1). bus_release=1, lcd_rw=0.
//   - SETUP: T_SETUP cycles. lcd_rw=1, lcd_rs=captured rs_sel.
//   - EH_HI: T_EHIGH cycles, lcd_e=1. sf_d_in is sampled into data[7:4] on the last E-high cycle.
//   - GAP: T_NIBGAP cycles, lcd_e=0.
//   - EH_LO: T_EHIGH cycles, lcd_e=1. sf_d_in is sampled into data[3:0] on the last E-high cycle.
//   - HOLD: T_HOLD cycles, lcd_e=0, lcd_rw still 1.
//   - RWDROP: 1 cycle. lcd_rw=0, lcd_rs=0, bus_release still 1.
//   - DONE: 1 cycle. bus_release=0, valid=1, ready=1; then IDLE.
// - Ordering: bus_release rises 1 cycle before lcd_rw rises and falls 1 cycle after lcd_rw falls.
//   The FPGA and the LCD never drive sf_d simultaneously.
// - Latency: valid at cycle 3+T_SETUP+2*T_EHIGH+T_NIBGAP+T_HOLD (= 80 at defaults).
// - start while ready=0 is ignored (not queued). start in the DONE cycle is accepted.
// - lcd_rs/lcd_rw do not change while lcd_e=1. lcd_e goes high only after a complete SETUP or GAP.
// - The counter is 16 bit and reloads at each state entry. Parameters of 0 are illegal.
// - data/addr/busy_flag hold their value until the next valid.
// CONFIGURATION
// - LCD_BUSY_POLL_EN defined:
//   - If rs_sel=0 and data[7]=1 after EH_LO, the FSM goes to GAP (T_NIBGAP) and then EH_HI again.
//     lcd_rw stays 1 and bus_release stays 1 throughout.
//   - Each completed read increments a poll count.
//   - The FSM exits to HOLD when a read shows data[7]=0, or when POLL_MAX reads have shown busy.
//     In the busy exit, timeout=1 in the DONE cycle.
//   - valid pulses once per transaction, not once per poll.
// - LCD_BUSY_POLL_EN undefined:
//   - Exactly one read per start. timeout is tied to 0.
// TESTING
// 1. Reset:
//    - Assert rst mid-idle: all outputs at their reset values.
//    - Release rst: ready=1, lcd_rw=0.
// 2. Status read, rs_sel=0, sf_d_in=3 during first E, 5 during second E:
//    - valid at cycle 80; data=0x35, busy_flag=0, addr=0x35.
//    - Each E pulse lasts 12 cycles; the gap is 50 cycles.
// 3. Data read, rs_sel=1, nibbles A then 7:
//    - data=0xA7, busy_flag=0.
//    - lcd_rs=1 from the first SETUP cycle through HOLD.
//    - bus_release edges bracket lcd_rw by exactly 1 cycle.
// 4. start pulsed at cycles 10 and 40 during a read:
//    - Both ignored; exactly one valid.
//    - start at the DONE cycle begins a new read.
// 5. rst asserted while lcd_e=1 (cycle 8):
//    - lcd_e=0, lcd_rw=0, bus_release=0 immediately.
//    - No valid is produced.
// 6. LCD_BUSY_POLL_EN, POLL_MAX=4:
//    - Busy high for 3 reads, then 0x0C: one valid, data=0x0C, timeout=0.
//    - Busy stuck high: valid with timeout=1 after 4 reads, data[7]=1.

Source files
------------

// File: rtl/lcd_read_nibbles.sv
// lcd_read_nibbles: two-nibble HD44780 read cycle on the 4-bit LCD bus.
// Define LCD_BUSY_POLL_EN to repeat status reads while busy, with a POLL_MAX timeout.
module lcd_read_nibbles #(
  parameter int T_SETUP = 2,
  parameter int T_EHIGH = 12,
  parameter int T_NIBGAP = 50,
  parameter int T_HOLD = 1
`ifdef LCD_BUSY_POLL_EN
  ,
  parameter int POLL_MAX = 1000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_sel,
  input  logic [3:0] sf_d_in,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       bus_release,
  output logic [7:0] data,
  output logic       busy_flag,
  output logic [6:0] addr,
  output logic       valid,
  output logic       ready,
  output logic       timeout
);
  typedef enum logic [3:0] {IDLE, RELEASE, SETUP, EH_HI, GAP, EH_LO, HOLD, RWDROP, DONE} state_t;
  state_t state, ns;
  logic [15:0] cnt;
  logic [3:0] hi, lo;
  logic rs_q, gap_hi, last, poll_again;
  assign last = cnt == 16'd0;
  assign addr = data[6:0];
  function automatic logic [15:0] dur(input state_t s);
    case (s)
      SETUP: dur = 16'(T_SETUP - 1);
      EH_HI, EH_LO: dur = 16'(T_EHIGH - 1);
      GAP: dur = 16'(T_NIBGAP - 1);
      HOLD: dur = 16'(T_HOLD - 1);
      default: dur = 16'd0;
    endcase
  endfunction
  always_comb begin
    ns = state;
    case (state)
      IDLE, DONE: ns = start ? RELEASE : IDLE;
      RELEASE: ns = SETUP;
      SETUP: ns = last ? EH_HI : SETUP;
      EH_HI: ns = last ? GAP : EH_HI;
      GAP: ns = last ? (gap_hi ? EH_HI : EH_LO) : GAP;
      EH_LO: ns = last ? (poll_again ? GAP : HOLD) : EH_LO;
      HOLD: ns = last ? RWDROP : HOLD;
      RWDROP: ns = DONE;
      default: ns = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with it exactly
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      rs_q <= 1'b0;
      gap_hi <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_rw <= 1'b0;
      lcd_e <= 1'b0;
      bus_release <= 1'b0;
      data <= '0;
      busy_flag <= 1'b0;
      valid <= 1'b0;
      ready <= 1'b1;
    end else begin
      state <= ns;
      cnt <= ns == state ? cnt - 16'd1 : dur(ns);
      rs_q <= ns == RELEASE ? rs_sel : rs_q;
      hi <= state == EH_HI && last ? sf_d_in : hi;
      lo <= state == EH_LO && last ? sf_d_in : lo;
      gap_hi <= state == EH_LO ? 1'b1 : state == EH_HI ? 1'b0 : gap_hi;
      lcd_e <= ns == EH_HI || ns == EH_LO;
      lcd_rw <= ns inside {SETUP, EH_HI, GAP, EH_LO, HOLD};
      lcd_rs <= ns inside {SETUP, EH_HI, GAP, EH_LO, HOLD} && rs_q;
      bus_release <= !(ns inside {IDLE, DONE});
      data <= ns == DONE ? {hi, lo} : data;
      busy_flag <= ns == DONE ? !rs_q && hi[3] : busy_flag;
      valid <= ns == DONE;
      ready <= ns == IDLE || ns == DONE;
    end
`ifdef LCD_BUSY_POLL_EN
  logic [15:0] polls;
  logic busy_rd, to_q;
  assign busy_rd = !rs_q && hi[3];
  assign poll_again = busy_rd && polls + 16'd1 != 16'(POLL_MAX);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      polls <= '0;
      to_q <= 1'b0;
      timeout <= 1'b0;
    end else begin
      polls <= ns == RELEASE ? '0 : state == EH_LO && last ? polls + 16'd1 : polls;
      to_q <= ns == RELEASE ? 1'b0 : state == EH_LO && last ? busy_rd : to_q;
      timeout <= ns == DONE && to_q;
    end
`else
  assign poll_again = 1'b0;
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_lcd_read_nibbles.sv
// tb_lcd_read_nibbles: directed and randomized reads checked against a cycle timeline model.
module tb_lcd_read_nibbles;
  localparam int TS = 2, TE = 12, TG = 50, TH = 1;
  localparam int E1 = 2 + TS, E2 = E1 + TE + TG, RWEND = E2 + TE + TH - 1, DN = RWEND + 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rs_sel = 1'b0;
  logic [3:0] sf_d_in = 4'h0;
  logic lcd_rs, lcd_rw, lcd_e, bus_release, busy_flag, valid, ready, timeout;
  logic [7:0] data;
  logic [6:0] addr;
  logic [7:0] last_d = 8'h00;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lcd_read_nibbles #(
    .T_SETUP(TS), .T_EHIGH(TE), .T_NIBGAP(TG), .T_HOLD(TH)
`ifdef LCD_BUSY_POLL_EN
    , .POLL_MAX(4)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rs_sel(rs_sel), .sf_d_in(sf_d_in),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .bus_release(bus_release),
    .data(data), .busy_flag(busy_flag), .addr(addr), .valid(valid), .ready(ready),
    .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  // one read starting this cycle; the LCD model shows the true nibble only on the last E-high cycle
  task automatic run_read(input bit rs, input logic [3:0] hi, input logic [3:0] lo, input bit pulses, input bit chain);
    logic [7:0] d;
    logic [3:0] nib;
    logic [6:0] ex;
    bit e_prev, e_x, rw_x, br_x;
    int ehc, k, nv;
    d = {hi, lo};
    start = 1'b1;
    rs_sel = rs;
    e_prev = 1'b0;
    ehc = 0;
    k = 0;
    nv = 0;
    for (int c = 1; c <= (chain ? DN : DN + 4); c++) begin
      @(negedge clk);
      start = pulses && (c == 10 || c == 40);
      rs_sel = ~rs;
      ehc = lcd_e ? ehc + 1 : 0;
      nib = k == 0 ? hi : lo;
      sf_d_in = lcd_e ? (ehc == TE ? nib : ~nib) : 4'($urandom);
      if (e_prev && !lcd_e) k++;
      e_prev = lcd_e;
      nv += int'(valid);
      e_x = (c >= E1 && c < E1 + TE) || (c >= E2 && c < E2 + TE);
      rw_x = c >= 2 && c <= RWEND;
      br_x = c >= 1 && c <= RWEND + 1;
      ex = {e_x, rw_x, rw_x & rs, br_x, c == DN, c >= DN, 1'b0};
      chk($sformatf("pins_c%0d", c), 32'({lcd_e, lcd_rw, lcd_rs, bus_release, valid, ready, timeout}), 32'(ex));
      if (c < DN) chk($sformatf("held_c%0d", c), 32'(data), 32'(last_d));
      else begin
        chk($sformatf("data_c%0d", c), 32'(data), 32'(d));
        chk($sformatf("busy_c%0d", c), 32'(busy_flag), 32'(!rs && hi[3]));
        chk($sformatf("addr_c%0d", c), 32'(addr), 32'(d[6:0]));
      end
    end
    chk("nvalid", 32'(nv), 32'd1);
    last_d = d;
  endtask
`ifdef LCD_BUSY_POLL_EN
  task automatic run_poll(input int n, input logic [7:0] fin);
    int p, nv, rd_exp;
    bit e_prev, to;
    logic [7:0] d_exp;
    p = 0;
    nv = 0;
    to = 1'b0;
    e_prev = 1'b0;
    rd_exp = n >= 4 ? 4 : n + 1;
    d_exp = n >= 4 ? 8'h80 : fin;
    start = 1'b1;
    rs_sel = 1'b0;
    for (int c = 1; c < 3000 && nv == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (lcd_e && !e_prev) begin
        sf_d_in = p / 2 < n ? (p % 2 == 0 ? 4'h8 : 4'h0) : (p % 2 == 0 ? fin[7:4] : fin[3:0]);
        p++;
      end
      e_prev = lcd_e;
      if (valid) begin
        nv++;
        to = timeout;
      end
    end
    chk("poll_valid", 32'(nv), 32'd1);
    chk("poll_reads", 32'(p), 32'(2 * rd_exp));
    chk("poll_data", 32'(data), 32'(d_exp));
    chk("poll_busy", 32'(busy_flag), 32'(d_exp[7]));
    chk("poll_timeout", 32'(to), 32'(n >= 4));
    repeat (3) @(negedge clk);
    last_d = d_exp;
  endtask
`endif
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit rs;
    logic [3:0] h;
    int nv;
    repeat (2) @(negedge clk);
    chk("rst_pins", 32'({lcd_e, lcd_rw, lcd_rs, bus_release, valid, ready, timeout}), 32'(7'b0000010));
    chk("rst_data", 32'({data, busy_flag, addr}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst", 32'({ready, lcd_rw}), 32'(2'b10));
    run_read(1'b0, 4'h3, 4'h5, 1'b0, 1'b0);
    run_read(1'b1, 4'hA, 4'h7, 1'b0, 1'b0);
    run_read(1'b1, 4'hC, 4'h1, 1'b1, 1'b1);
    run_read(1'b0, 4'h2, 4'hE, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rs = 1'($urandom);
      h = 4'($urandom);
`ifdef LCD_BUSY_POLL_EN
      if (!rs) h[3] = 1'b0;
`endif
      run_read(rs, h, 4'($urandom), 1'($urandom), 1'b0);
    end
    rst = 1'b1;
    #1;
    chk("idle_rst", 32'({data, valid, ready, lcd_rw}), 32'({8'h00, 3'b010}));
    @(negedge clk);
    rst = 1'b0;
    last_d = 8'h00;
    start = 1'b1;
    rs_sel = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("e_at_c8", 32'(lcd_e), 32'd1);
    rst = 1'b1;
    #1;
    chk("midread_rst", 32'({lcd_e, lcd_rw, lcd_rs, bus_release, valid, ready}), 32'(6'b000001));
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      nv += int'(valid) + int'(lcd_e);
    end
    chk("no_valid_after_rst", 32'(nv), 32'd0);
    chk("ready_after_rst", 32'(ready), 32'd1);
    run_read(1'b0, 4'h6, 4'h9, 1'b0, 1'b0);
`ifdef LCD_BUSY_POLL_EN
    run_poll(3, 8'h0C);
    run_poll(100, 8'h00);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
